// File: rtl/ch_measure_core_if.sv
// Bus bundle for ch_measure_core: run control, async reference input,
// DAC threshold handshake, comparator, strobe/delay line and point output.
interface ch_measure_core_if;
  logic        run_i;
  logic        sig_i;
  logic [15:0] threshold_delta_i;
  logic [9:0]  d_code_delta_i;
  logic [15:0] threshold_o;
  logic        threshold_wre_o;
  logic        threshold_rdy_i;
  logic        cmp_out_i;
  logic        stb_o;
  logic [9:0]  d_code_o;
  logic        stb_rdy_o;
  logic        stb_err_o;
  logic        point_rdy_o;
  logic [15:0] point_v_o;
  logic [9:0]  point_t_o;

  // Design side
  modport slave (
    input  run_i, sig_i, threshold_delta_i, d_code_delta_i,
    input  threshold_rdy_i, cmp_out_i,
    output threshold_o, threshold_wre_o, stb_o, d_code_o,
    output stb_rdy_o, stb_err_o, point_rdy_o, point_v_o, point_t_o
  );

  // Driver / environment side
  modport master (
    output run_i, sig_i, threshold_delta_i, d_code_delta_i,
    output threshold_rdy_i, cmp_out_i,
    input  threshold_o, threshold_wre_o, stb_o, d_code_o,
    input  stb_rdy_o, stb_err_o, point_rdy_o, point_v_o, point_t_o
  );
endinterface

// File: rtl/ch_measure_core.sv
// Equivalent-time channel sampler: a strobe generator phase-locked to the
// rising edge of sig_i, plus a controller that, for every delay code, steps
// the DAC threshold up until the latched comparator flips and then reports
// the (delay code, threshold) point.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for run with a locked, fault-free reference
// S_SET_THR  | load DAC code, emit one-cycle write pulse
// S_WAIT_DAC | wait for DAC settle (first cycle's ready is stale, ignored)
// S_REQ_STB  | request one strobe from the generator
// S_WAIT_STB | wait for the strobe's last cycle, latch comparator
// S_EVAL     | step threshold up, or report the point
// S_EMIT     | advance delay code, or finish after code 1023
// S_DONE     | sweep complete, hold until run drops
module ch_measure_core #(
  parameter int STB_WIDTH   = 64,
  parameter int PERIOD_W    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               arst_i,
  ch_measure_core_if.slave   bus
);

  localparam int STB_CW = (STB_WIDTH > 1) ? $clog2(STB_WIDTH) : 1;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
  localparam logic [15:0] THR_MAX  = 16'hFFFF;
  localparam logic [9:0]  CODE_MAX = 10'd1023;

  typedef enum logic [2:0] {
    S_IDLE, S_SET_THR, S_WAIT_DAC, S_REQ_STB,
    S_WAIT_STB, S_EVAL, S_EMIT, S_DONE
  } state_t;

  state_t state_q;

  // ------------------------------------------------------------------
  // Reference input synchroniser and edge detect
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_prev_q;
  logic                   sig_s;
  logic                   rise;

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_prev_q;

  // Shift sig_i through the synchroniser chain and keep the previous value.
  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      sync_q     <= '0;
      sig_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.sig_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sig_prev_q <= sig_s;
    end
  end

  // ------------------------------------------------------------------
  // Period watchdog and lock detect
  // ------------------------------------------------------------------
  logic [PERIOD_W-1:0] period_q;
  logic [1:0]          edge_cnt_q;
  logic                stb_rdy_q;
  logic                stb_err_q;

  // Count cycles between edges; saturating without an edge is a sticky fault.
  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      period_q   <= '0;
      edge_cnt_q <= 2'd0;
      stb_rdy_q  <= 1'b0;
      stb_err_q  <= 1'b0;
    end else begin
      if (rise) period_q <= '0;
      else if (period_q != PERIOD_MAX) period_q <= period_q + 1'b1;
      if (!rise && period_q == PERIOD_MAX) stb_err_q <= 1'b1;
      if (rise && edge_cnt_q != 2'd2) edge_cnt_q <= edge_cnt_q + 2'd1;
      if (rise && edge_cnt_q == 2'd1) stb_rdy_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Strobe generator
  // ------------------------------------------------------------------
  logic              stb_q;
  logic              stb_pend_q;
  logic [STB_CW-1:0] stb_cnt_q;
  logic              stb_req_q;
  logic              stb_valid;
  logic              abort;

  // Abort overrides everything in the controller and kills the strobe.
  assign abort     = (state_q != S_IDLE) & (~bus.run_i | stb_err_q);
  assign stb_valid = stb_q & (stb_cnt_q == '0);

  // Arm on request, fire on the next synchronised edge, hold STB_WIDTH cycles.
  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      stb_q      <= 1'b0;
      stb_pend_q <= 1'b0;
      stb_cnt_q  <= '0;
    end else if (abort) begin
      stb_q      <= 1'b0;
      stb_pend_q <= 1'b0;
      stb_cnt_q  <= '0;
    end else if (stb_q) begin
      if (stb_cnt_q == '0) stb_q <= 1'b0;
      else stb_cnt_q <= stb_cnt_q - 1'b1;
    end else if ((stb_pend_q | stb_req_q) & rise) begin
      stb_q      <= 1'b1;
      stb_cnt_q  <= STB_CW'(STB_WIDTH - 1);
      stb_pend_q <= 1'b0;
    end else if (stb_req_q) begin
      stb_pend_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Controller
  // ------------------------------------------------------------------
  logic [15:0] thr_q;
  logic [9:0]  d_code_q;
  logic [15:0] thr_out_q;
  logic        wre_q;
  logic        dac_first_q;
  logic        cmp_q;
  logic        point_rdy_q;
  logic [15:0] point_v_q;
  logic [9:0]  point_t_q;

  logic [15:0] thr_step;
  logic [9:0]  d_step;
  logic [16:0] thr_sum;
  logic [10:0] d_sum;
  logic [15:0] thr_d;
  logic [9:0]  d_code_d;

  // A zero step would stall the sweep, so it is promoted to one.
  assign thr_step = (bus.threshold_delta_i == 16'd0) ? 16'd1 : bus.threshold_delta_i;
  assign d_step   = (bus.d_code_delta_i == 10'd0) ? 10'd1 : bus.d_code_delta_i;
  assign thr_sum  = {1'b0, thr_q} + {1'b0, thr_step};
  assign d_sum    = {1'b0, d_code_q} + {1'b0, d_step};
  assign thr_d    = thr_sum[16] ? THR_MAX : thr_sum[15:0];
  assign d_code_d = d_sum[10] ? CODE_MAX : d_sum[9:0];

  // Sweep sequencing with registered DAC, strobe-request and point outputs.
  always_ff @(posedge clk_i) begin
    if (!arst_i) begin
      state_q     <= S_IDLE;
      thr_q       <= 16'd0;
      d_code_q    <= 10'd0;
      thr_out_q   <= 16'd0;
      wre_q       <= 1'b0;
      dac_first_q <= 1'b0;
      stb_req_q   <= 1'b0;
      cmp_q       <= 1'b0;
      point_rdy_q <= 1'b0;
      point_v_q   <= 16'd0;
      point_t_q   <= 10'd0;
    end else begin
      wre_q       <= 1'b0;
      point_rdy_q <= 1'b0;
      stb_req_q   <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        dac_first_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.run_i && stb_rdy_q && !stb_err_q) begin
              d_code_q <= 10'd0;
              thr_q    <= 16'd0;
              state_q  <= S_SET_THR;
            end
          end
          S_SET_THR: begin
            thr_out_q   <= thr_q;
            wre_q       <= 1'b1;
            dac_first_q <= 1'b1;
            state_q     <= S_WAIT_DAC;
          end
          S_WAIT_DAC: begin
            if (dac_first_q) dac_first_q <= 1'b0;
            else if (bus.threshold_rdy_i) state_q <= S_REQ_STB;
          end
          S_REQ_STB: begin
            stb_req_q <= 1'b1;
            state_q   <= S_WAIT_STB;
          end
          S_WAIT_STB: begin
            if (stb_valid) begin
              cmp_q   <= bus.cmp_out_i;
              state_q <= S_EVAL;
            end
          end
          S_EVAL: begin
            if (cmp_q && thr_q != THR_MAX) begin
              thr_q   <= thr_d;
              state_q <= S_SET_THR;
            end else begin
              // Point published here so it lands 2 cycles after the valid cycle.
              point_v_q   <= thr_q;
              point_t_q   <= d_code_q;
              point_rdy_q <= 1'b1;
              state_q     <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (d_code_q == CODE_MAX) begin
              state_q <= S_DONE;
            end else begin
              d_code_q <= d_code_d;
              thr_q    <= 16'd0;
              state_q  <= S_SET_THR;
            end
          end
          S_DONE: state_q <= S_DONE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.threshold_o     = thr_out_q;
  assign bus.threshold_wre_o = wre_q;
  assign bus.stb_o           = stb_q;
  assign bus.d_code_o        = d_code_q;
  assign bus.stb_rdy_o       = stb_rdy_q;
  assign bus.stb_err_o       = stb_err_q;
  assign bus.point_rdy_o     = point_rdy_q;
  assign bus.point_v_o       = point_v_q;
  assign bus.point_t_o       = point_t_q;

endmodule

// File: tb/tb_ch_measure_core.sv
// Bench for ch_measure_core: table of single-point sweeps plus hand-written
// lock, full sweep / restart, abort and edge-timeout sequences.
module tb_ch_measure_core;

  localparam int STB_W = 8;
  localparam int PW    = 8;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  ch_measure_core_if bus();

  ch_measure_core #(.STB_WIDTH(STB_W), .PERIOD_W(PW), .SYNC_STAGES(2)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference input: 200 ns period, offset from the clock edges.
  logic sig_en = 1'b1;
  int   sig_rises = 0;
  initial begin
    logic nv;
    bus.sig_i = 1'b0;
    #3;
    forever begin
      #100;
      nv = sig_en ? ~bus.sig_i : 1'b0;
      if (nv && !bus.sig_i) sig_rises++;
      bus.sig_i = nv;
    end
  end

  // DAC model: ready drops on a write and returns 5 cycles later.
  int dac_cnt = 0;
  always @(posedge clk) begin
    if (bus.threshold_wre_o) dac_cnt <= 5;
    else if (dac_cnt != 0) dac_cnt <= dac_cnt - 1;
  end
  always_comb bus.threshold_rdy_i = (dac_cnt == 0);

  // Comparator model: signal level cmp_lim, comparator says signal >= threshold.
  logic        cmp_en  = 1'b0;
  logic [15:0] cmp_lim = 16'd0;
  always_comb bus.cmp_out_i = cmp_en && (bus.threshold_o <= cmp_lim);

  // Monitor sampled on the falling edge.
  logic [15:0] wr_q[$];
  logic [15:0] pv_q[$];
  logic [9:0]  pt_q[$];
  int          width_err = 0;
  int          dstab_err = 0;
  logic        prev_wre = 1'b0, prev_prdy = 1'b0, prev_stb = 1'b0;
  logic [9:0]  prev_dc = 10'd0;
  always @(negedge clk) begin
    if (bus.threshold_wre_o) wr_q.push_back(bus.threshold_o);
    if (bus.point_rdy_o) begin
      pv_q.push_back(bus.point_v_o);
      pt_q.push_back(bus.point_t_o);
    end
    if ((bus.threshold_wre_o && prev_wre) || (bus.point_rdy_o && prev_prdy)) width_err++;
    if (bus.stb_o && prev_stb && bus.d_code_o != prev_dc) dstab_err++;
    prev_wre  = bus.threshold_wre_o;
    prev_prdy = bus.point_rdy_o;
    prev_stb  = bus.stb_o;
    prev_dc   = bus.d_code_o;
  end

  task automatic clear_mon();
    wr_q.delete();
    pv_q.delete();
    pt_q.delete();
  endtask

  // Reset, release just after a sig_i fall, then wait (bounded) for lock.
  task automatic do_reset();
    int k;
    bus.run_i = 1'b0;
    arst = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge bus.sig_i);
    @(negedge clk);
    arst = 1'b1;
    k = 0;
    while (!bus.stb_rdy_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("lock", bus.stb_rdy_o, 1);
  endtask

  task automatic wait_points(input int n, input int bound);
    int k = 0;
    while (pv_q.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
  endtask

  typedef struct {
    logic [15:0] thr_delta;
    logic        cmp_on;
    logic [15:0] lim;
    logic [15:0] exp_v;
    int          exp_nwr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k, r0, nw, np;
    longint step, e;
    logic [9:0] exp_t[5];

    vecs[0] = '{16'd16,    1'b1, 16'd40,    16'd48,    4};
    vecs[1] = '{16'd0,     1'b1, 16'd2,     16'd3,     4};
    vecs[2] = '{16'h4000,  1'b1, 16'hFFFF,  16'hFFFF,  5};
    vecs[3] = '{16'h8000,  1'b1, 16'h7FFF,  16'h8000,  2};
    vecs[4] = '{16'd16,    1'b0, 16'd0,     16'd0,     1};
    exp_t[0] = 10'd0;   exp_t[1] = 10'd256; exp_t[2] = 10'd512;
    exp_t[3] = 10'd768; exp_t[4] = 10'd1023;

    bus.run_i = 1'b0;
    bus.threshold_delta_i = 16'd16;
    bus.d_code_delta_i = 10'd1;

    // Reset state and lock after two edges
    arst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_thr",   bus.threshold_o, 0);
    chk("rst_wre",   bus.threshold_wre_o, 0);
    chk("rst_stb",   bus.stb_o, 0);
    chk("rst_dcode", bus.d_code_o, 0);
    chk("rst_rdy",   bus.stb_rdy_o, 0);
    chk("rst_err",   bus.stb_err_o, 0);
    chk("rst_prdy",  bus.point_rdy_o, 0);
    chk("rst_pv",    bus.point_v_o, 0);
    chk("rst_pt",    bus.point_t_o, 0);
    @(negedge bus.sig_i);
    @(negedge clk);
    arst = 1'b1;
    r0 = sig_rises;
    k = 0;
    while (!bus.stb_rdy_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("lock_after_2_edges", sig_rises - r0, 2);
    chk("lock_level", bus.stb_rdy_o, 1);

    // Table-driven single-point sweeps
    for (int i = 0; i < 5; i++) begin
      do_reset();
      bus.threshold_delta_i = vecs[i].thr_delta;
      bus.d_code_delta_i = 10'd1;
      cmp_en  = vecs[i].cmp_on;
      cmp_lim = vecs[i].lim;
      clear_mon();
      bus.run_i = 1'b1;
      wait_points(1, 2000);
      bus.run_i = 1'b0;
      repeat (5) @(negedge clk);
      chk("vec_point_seen", (pv_q.size() >= 1), 1);
      if (pv_q.size() >= 1) begin
        chk("vec_point_v", pv_q[0], vecs[i].exp_v);
        chk("vec_point_t", pt_q[0], 0);
      end
      chk("vec_nwrites", wr_q.size(), vecs[i].exp_nwr);
      step = (vecs[i].thr_delta == 16'd0) ? 1 : longint'(vecs[i].thr_delta);
      for (int j = 0; j < wr_q.size(); j++) begin
        e = j * step;
        if (e > 65535) e = 65535;
        chk("vec_write_val", wr_q[j], e[15:0]);
      end
    end

    // Full sweep to code 1023, then hold, then restart on run toggle
    do_reset();
    bus.threshold_delta_i = 16'd16;
    bus.d_code_delta_i = 10'd256;
    cmp_en = 1'b1;
    cmp_lim = 16'd40;
    clear_mon();
    bus.run_i = 1'b1;
    wait_points(5, 4000);
    repeat (300) @(negedge clk);
    chk("sweep_npoints", pv_q.size(), 5);
    for (int j = 0; j < 5 && j < pv_q.size(); j++) begin
      chk("sweep_t", pt_q[j], exp_t[j]);
      chk("sweep_v", pv_q[j], 16'd48);
    end
    chk("sweep_nwrites_done", wr_q.size(), 20);
    bus.run_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.run_i = 1'b1;
    k = 0;
    while (wr_q.size() <= 20 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("restart_write_seen", (wr_q.size() > 20), 1);
    if (wr_q.size() > 20) chk("restart_thr", wr_q[20], 0);
    chk("restart_dcode", bus.d_code_o, 0);
    wait_points(6, 2000);
    chk("restart_point_seen", (pt_q.size() >= 6), 1);
    if (pt_q.size() >= 6) chk("restart_point_t", pt_q[5], 0);
    bus.run_i = 1'b0;
    repeat (5) @(negedge clk);

    // Abort while strobe is high
    do_reset();
    bus.threshold_delta_i = 16'd16;
    bus.d_code_delta_i = 10'd256;
    cmp_en = 1'b1;
    cmp_lim = 16'd40;
    clear_mon();
    bus.run_i = 1'b1;
    k = 0;
    while (!(wr_q.size() >= 3 && bus.stb_o) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("abort_stb_seen", bus.stb_o, 1);
    np = pv_q.size();
    nw = wr_q.size();
    bus.run_i = 1'b0;
    @(negedge clk);
    chk("abort_stb_low", bus.stb_o, 0);
    chk("abort_thr_held", bus.threshold_o, 16'd32);
    repeat (100) @(negedge clk);
    chk("abort_no_point", pv_q.size(), np);
    chk("abort_no_write", wr_q.size(), nw);
    chk("abort_thr_still", bus.threshold_o, 16'd32);

    // Edge timeout with sig_i stuck low
    sig_en = 1'b0;
    repeat (30) @(negedge clk);
    arst = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    clear_mon();
    bus.run_i = 1'b1;
    repeat (250) @(negedge clk);
    chk("timeout_err_early", bus.stb_err_o, 0);
    repeat (20) @(negedge clk);
    chk("timeout_err", bus.stb_err_o, 1);
    chk("timeout_no_lock", bus.stb_rdy_o, 0);
    repeat (20) @(negedge clk);
    chk("timeout_no_write", wr_q.size(), 0);
    chk("timeout_err_sticky", bus.stb_err_o, 1);
    bus.run_i = 1'b0;

    chk("pulse_width", width_err, 0);
    chk("dcode_stable_in_strobe", dstab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
